player_input_queue: RTL

//  Per-player action queue downstream of the keyboard controller: one instance per control0..3 output.

---
 rtl/player_input_queue_if.sv | 24 ++
 rtl/player_input_queue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/player_input_queue_if.sv
// Handshake bundle between a per-player input queue and its producer/consumer.
// The master side drives control pulses, flush and ready; the slave is the queue.
interface player_input_queue_if #(
  parameter int AW = 2
) ();
  logic [3:0]  ctrl_in;
  logic        flush;
  logic        act_ready;
  logic [3:0]  act_out;
  logic        act_valid;
  logic [AW:0] count;
  logic        full;
  logic        overflow;

  modport master (
    output ctrl_in, flush, act_ready,
    input  act_out, act_valid, count, full, overflow
  );

  modport slave (
    input  ctrl_in, flush, act_ready,
    output act_out, act_valid, count, full, overflow
  );
endinterface

// File: rtl/player_input_queue.sv
// Per-player action FIFO with repeated-code holdoff filtering and valid/ready drain.
// Define INPUT_QUEUE_DROP_OLDEST_EN to overwrite the oldest entry on overflow instead of dropping the new one.
module player_input_queue #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int HOLDOFF = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  player_input_queue_if.slave  q
);

  localparam int          HW        = $clog2(HOLDOFF + 1);
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [HW-1:0] HOLD_C  = HW'(HOLDOFF);

  typedef logic [3:0] code_t;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  code_t         last_code_q, last_code_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic          overflow_q, overflow_d;
  code_t         mem_q [DEPTH];

  logic is_full, is_empty, accept, pop, push, wr_en;

  function automatic logic is_legal(input code_t c);
    case (c)
      4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0011, 4'b1100: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_code_d = last_code_q;
    holdoff_d   = holdoff_q;
    overflow_d  = 1'b0;
    wr_en       = 1'b0;
    push        = 1'b0;

    is_full  = (count_q == DEPTH_C);
    is_empty = (count_q == '0);
    accept   = is_legal(q.ctrl_in) &&
               !((q.ctrl_in == last_code_q) && (holdoff_q != '0));
    pop      = !is_empty && q.act_ready;

    if (q.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      last_code_d = '0;
      holdoff_d   = '0;
    end else begin
      if (accept) begin
        last_code_d = q.ctrl_in;
        holdoff_d   = HOLD_C;
      end else if (holdoff_q != '0) begin
        holdoff_d = holdoff_q - HW'(1);
      end

      push = accept && (!is_full || pop);
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end

      if (accept && is_full && !pop) begin
        overflow_d = 1'b1;
`ifdef INPUT_QUEUE_DROP_OLDEST_EN
        // When full, wr_ptr == rd_ptr: overwrite the oldest slot and slide the window.
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        rd_ptr_d = rd_ptr_q + AW'(1);
`endif
      end

      case ({push, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_code_q <= '0;
      holdoff_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_code_q <= last_code_d;
      holdoff_q   <= holdoff_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: storage is not reset; count gates act_out, so stale contents are never visible.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= q.ctrl_in;
    end
  end

  assign q.act_valid = !is_empty;
  assign q.act_out   = is_empty ? 4'b0000 : mem_q[rd_ptr_q];
  assign q.count     = count_q;
  assign q.full      = is_full;
  assign q.overflow  = overflow_q;

endmodule
